// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: one multiplier bit per cycle into a carry-save
// accumulator, then a single resolve add, with valid/ready on both sides.

module csa #(
  parameter int WD = 25
) (
  input  logic [WD-1:0] x,
  input  logic [WD-1:0] y,
  input  logic [WD-1:0] z,
  output logic [WD-1:0] sum,
  output logic [WD-1:0] carry
);
  logic [WD-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  // Carry already carries weight 2: shift left, drop the bit leaving the word.
  assign carry = {maj[WD-2:0], 1'b0};
endmodule

module mult_seq_ctrl #(
  parameter int MD_WD   = 16,
  parameter int MR_WD   = 9,
  parameter int MDMR_WD = MD_WD + MR_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MD_WD-1:0]   in_md,
  input  logic [MR_WD-1:0]   in_mr,
  input  logic               abort,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MDMR_WD-1:0] out_prod
);
  localparam int CNT_WD = (MR_WD > 1) ? $clog2(MR_WD) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(MR_WD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic [MDMR_WD-1:0] sum;
  logic [MDMR_WD-1:0] carry;
  logic [MD_WD-1:0]   md_r;
  logic [MR_WD-1:0]   mr_r;
  logic [CNT_WD-1:0]  cnt;

  logic [MDMR_WD-1:0] pp;
  logic [MDMR_WD-1:0] csa_sum;
  logic [MDMR_WD-1:0] csa_carry;

  // Partial product for the bit currently being retired; zero bits still cost a cycle.
  assign pp = mr_r[cnt] ? ({{MR_WD{1'b0}}, md_r} << cnt) : '0;

  csa #(.WD(MDMR_WD)) u_csa (
    .x     (sum),
    .y     (carry),
    .z     (pp),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // NOTE: all state, including the handshake outputs, updates with non-blocking
  // assignments so every register samples pre-edge values consistently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
      md_r      <= '0;
      mr_r      <= '0;
      cnt       <= '0;
      out_prod  <= '0;
    end else if (abort) begin
      // Abort outranks both handshakes; the last product stays visible but invalid.
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            md_r     <= in_md;
            mr_r     <= in_mr;
            sum      <= '0;
            carry    <= '0;
            cnt      <= '0;
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          sum   <= csa_sum;
          carry <= csa_carry;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RESOLVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESOLVE: begin
          out_prod  <= sum + carry;
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
